// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared constants for the multi-channel clock-enable divider.
//   CLKDIV_DEF_DIV  : divisor loaded into every channel at reset (N = D+1)
//   CLKDIV_NCH_MAX  : largest supported channel count
//   LD_CH_W         : width of the load channel index
// -----------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int CLKDIV_DEF_DIV = 3;
  localparam int CLKDIV_NCH_MAX = 16;
  localparam int LD_CH_W        = 4;

endpackage

// File: rtl/clkdiv_multi_if.sv
// -----------------------------------------------------------------------------
// clkdiv_multi_if
// Control/status bundle for clkdiv_multi.
//   run[NCH]      : per-channel run enable
//   sync          : one-cycle phase-align strobe for all running channels
//   ld, ld_ch     : divisor load strobe and target channel
//   ld_val[WIDTH] : new divisor D (period N = D+1)
//   en[NCH]       : one-cycle enable pulse per channel
//   sq[NCH]       : 50 % square wave, period 2N
//   pend[NCH]     : shadow divisor waiting to be applied
// master drives the controls, slave (the divider) drives the status.
// -----------------------------------------------------------------------------
interface clkdiv_multi_if
  import clkdiv_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 18
) ();

  logic [NCH-1:0]     run;
  logic               sync;
  logic               ld;
  logic [LD_CH_W-1:0] ld_ch;
  logic [WIDTH-1:0]   ld_val;
  logic [NCH-1:0]     en;
  logic [NCH-1:0]     sq;
  logic [NCH-1:0]     pend;

  modport master (
    output run, sync, ld, ld_ch, ld_val,
    input  en, sq, pend
  );

  modport slave (
    input  run, sync, ld, ld_ch, ld_val,
    output en, sq, pend
  );

endinterface

// File: rtl/clkdiv_chan.sv
// -----------------------------------------------------------------------------
// clkdiv_chan
// One divider channel: down-counter reloaded on terminal count (cnt == 0),
// with an active divisor and a shadow divisor that is swapped in at the next
// terminal (or immediately while the channel is idle).
//   clk, rst    : clock, async active-low reset
//   run         : channel enable; 0 holds the counter idle at 0
//   sync        : force terminal on the following cycle
//   ld, ld_val  : already-decoded load strobe and new divisor
//   en, sq, pend: registered enable pulse, square wave, shadow-pending flag
// -----------------------------------------------------------------------------
module clkdiv_chan #(
  parameter int WIDTH   = 18,
  parameter int DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             sync,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic             en,
  output logic             sq,
  output logic             pend
);

  localparam logic [WIDTH-1:0] DEF_VAL = WIDTH'(DEF_DIV);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] div_shd;
  logic [WIDTH-1:0] reload;

  // Reload only ever sees the shadow as it stood before this edge, so a load
  // landing on a terminal cycle waits for the next terminal.
  assign reload = pend ? div_shd : div_act;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      div_act <= DEF_VAL;
      div_shd <= DEF_VAL;
      pend    <= 1'b0;
      en      <= 1'b0;
      sq      <= 1'b0;
    end else begin
      if (!run) begin
        cnt <= '0;
        en  <= 1'b0;
        sq  <= 1'b0;
        if (pend) begin
          div_act <= div_shd;
          pend    <= 1'b0;
        end
      end else if (sync) begin
        cnt <= '0;
        en  <= 1'b0;
        sq  <= 1'b0;
      end else if (cnt == '0) begin
        en      <= 1'b1;
        sq      <= ~sq;
        cnt     <= reload;
        div_act <= reload;
        pend    <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
        en  <= 1'b0;
      end
      // Placed last so a same-cycle load always leaves pend set.
      if (ld) begin
        div_shd <= ld_val;
        pend    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// -----------------------------------------------------------------------------
// clkdiv_multi
// NCH independent clock-enable dividers sharing a load port and a sync strobe.
//   clk : master clock, rising edge
//   rst : asynchronous active-low reset
//   bus : clkdiv_multi_if.slave (run/sync/ld/ld_ch/ld_val in, en/sq/pend out)
// Loads addressed to ld_ch >= NCH match no channel and are dropped.
// -----------------------------------------------------------------------------
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int WIDTH   = 18,
  parameter int DEF_DIV = CLKDIV_DEF_DIV
) (
  input logic           clk,
  input logic           rst,
  clkdiv_multi_if.slave bus
);

  logic [NCH-1:0] en_w;
  logic [NCH-1:0] sq_w;
  logic [NCH-1:0] pend_w;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic ld_hit;

    assign ld_hit = bus.ld && (bus.ld_ch == LD_CH_W'(i));

    clkdiv_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .run    (bus.run[i]),
      .sync   (bus.sync),
      .ld     (ld_hit),
      .ld_val (bus.ld_val),
      .en     (en_w[i]),
      .sq     (sq_w[i]),
      .pend   (pend_w[i])
    );
  end

  assign bus.en   = en_w;
  assign bus.sq   = sq_w;
  assign bus.pend = pend_w;

endmodule

// File: tb/tb_clkdiv_multi.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_multi
// Directed bench for clkdiv_multi: a 4-channel/18-bit instance and a
// 2-channel/4-bit instance for the divisor extremes.
// Cycle k = k-th rising edge after the stimulus starts; outputs are sampled
// 1 ns after that edge, inputs for edge k+1 are changed right after sampling.
// -----------------------------------------------------------------------------
module tb_clkdiv_multi;
  import clkdiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  clkdiv_multi_if #(.NCH(4), .WIDTH(18)) bus   ();
  clkdiv_multi_if #(.NCH(2), .WIDTH(4))  bus_s ();

  clkdiv_multi #(.NCH(4), .WIDTH(18), .DEF_DIV(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  clkdiv_multi #(.NCH(2), .WIDTH(4), .DEF_DIV(3)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.run      = '0;
    bus.sync     = 1'b0;
    bus.ld       = 1'b0;
    bus.ld_ch    = '0;
    bus.ld_val   = '0;
    bus_s.run    = '0;
    bus_s.sync   = 1'b0;
    bus_s.ld     = 1'b0;
    bus_s.ld_ch  = '0;
    bus_s.ld_val = '0;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1'b0;
    #12;
    checks++; if (bus.en !== 4'b0000)   begin errors++; $display("FAIL reset_en got=%b exp=0000", bus.en); end
    checks++; if (bus.sq !== 4'b0000)   begin errors++; $display("FAIL reset_sq got=%b exp=0000", bus.sq); end
    checks++; if (bus.pend !== 4'b0000) begin errors++; $display("FAIL reset_pend got=%b exp=0000", bus.pend); end
    checks++; if (bus_s.en !== 2'b00)   begin errors++; $display("FAIL reset_s_en got=%b exp=00", bus_s.en); end
    checks++; if (bus_s.sq !== 2'b00)   begin errors++; $display("FAIL reset_s_sq got=%b exp=00", bus_s.sq); end
    checks++; if (bus_s.pend !== 2'b00) begin errors++; $display("FAIL reset_s_pend got=%b exp=00", bus_s.pend); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ch0 alone at D=3: en at 1,5,9,13; sq high for 1..4, low for 5..8.
  task automatic test_basic();
    logic [3:0] exp_en, exp_sq;
    do_reset();
    bus.run = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_en = ((k - 1) % 4 == 0) ? 4'b0001 : 4'b0000;
      exp_sq = (((k - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0000;
      checks++; if (bus.en !== exp_en) begin errors++; $display("FAIL basic_en k=%0d got=%b exp=%b", k, bus.en, exp_en); end
      checks++; if (bus.sq !== exp_sq) begin errors++; $display("FAIL basic_sq k=%0d got=%b exp=%b", k, bus.sq, exp_sq); end
    end
    bus.run = 4'b0000;
    tick();
    checks++; if (bus.en !== 4'b0000 || bus.sq !== 4'b0000) begin errors++; $display("FAIL basic_stop got en=%b sq=%b exp 0000/0000", bus.en, bus.sq); end
  endtask

  // ch1 D=3, load 9 before edge 3: en at 1,5,15,25; pend high for 3..4.
  task automatic test_load_mid();
    logic [3:0] exp_en, exp_pend;
    do_reset();
    bus.run = 4'b0010;
    for (int k = 1; k <= 26; k++) begin
      tick();
      exp_en   = (k == 1 || k == 5 || k == 15 || k == 25) ? 4'b0010 : 4'b0000;
      exp_pend = (k == 3 || k == 4) ? 4'b0010 : 4'b0000;
      checks++; if (bus.en !== exp_en)     begin errors++; $display("FAIL ldmid_en k=%0d got=%b exp=%b", k, bus.en, exp_en); end
      checks++; if (bus.pend !== exp_pend) begin errors++; $display("FAIL ldmid_pend k=%0d got=%b exp=%b", k, bus.pend, exp_pend); end
      bus.ld     = (k == 2);
      bus.ld_ch  = 4'd1;
      bus.ld_val = 18'd9;
    end
    bus.ld = 1'b0;
  endtask

  // ch0 D=3, load 7 on the terminal edge 5: en at 1,5,9,17,25; pend 5..8.
  task automatic test_load_terminal();
    logic [3:0] exp_en, exp_pend;
    do_reset();
    bus.run = 4'b0001;
    for (int k = 1; k <= 26; k++) begin
      tick();
      exp_en   = (k == 1 || k == 5 || k == 9 || k == 17 || k == 25) ? 4'b0001 : 4'b0000;
      exp_pend = (k >= 5 && k <= 8) ? 4'b0001 : 4'b0000;
      checks++; if (bus.en !== exp_en)     begin errors++; $display("FAIL ldterm_en k=%0d got=%b exp=%b", k, bus.en, exp_en); end
      checks++; if (bus.pend !== exp_pend) begin errors++; $display("FAIL ldterm_pend k=%0d got=%b exp=%b", k, bus.pend, exp_pend); end
      bus.ld     = (k == 4);
      bus.ld_ch  = 4'd0;
      bus.ld_val = 18'd7;
    end
    bus.ld = 1'b0;
  endtask

  // ch0 D=3 from edge 1, ch2 D=5 from edge 3, sync on edge 7.
  // ch0 en: 1,5,8,12,16,20,24   ch2 en: 3,8,14,20,26
  task automatic test_sync();
    logic [31:0] m0, m2;
    logic [3:0]  exp_en;
    m0 = (32'd1 << 1) | (32'd1 << 5) | (32'd1 << 8) | (32'd1 << 12) |
         (32'd1 << 16) | (32'd1 << 20) | (32'd1 << 24);
    m2 = (32'd1 << 3) | (32'd1 << 8) | (32'd1 << 14) | (32'd1 << 20) | (32'd1 << 26);
    do_reset();
    bus.ld     = 1'b1;
    bus.ld_ch  = 4'd2;
    bus.ld_val = 18'd5;
    tick();
    bus.ld = 1'b0;
    checks++; if (bus.pend !== 4'b0100) begin errors++; $display("FAIL sync_idle_pend_set got=%b exp=0100", bus.pend); end
    tick();
    checks++; if (bus.pend !== 4'b0000) begin errors++; $display("FAIL sync_idle_pend_clr got=%b exp=0000", bus.pend); end
    bus.run = 4'b0001;
    for (int k = 1; k <= 26; k++) begin
      tick();
      exp_en = {1'b0, m2[k], 1'b0, m0[k]};
      checks++; if (bus.en !== exp_en) begin errors++; $display("FAIL sync_en k=%0d got=%b exp=%b", k, bus.en, exp_en); end
      if (k == 7) begin
        checks++; if ((bus.sq & 4'b0101) !== 4'b0000) begin errors++; $display("FAIL sync_sq_clr got=%b exp=x0x0", bus.sq); end
      end
      if (k == 8) begin
        checks++; if ((bus.sq & 4'b0101) !== 4'b0101) begin errors++; $display("FAIL sync_sq_set got=%b exp=x1x1", bus.sq); end
      end
      if (k == 2) bus.run = 4'b0101;
      bus.sync = (k == 6);
    end
    bus.sync = 1'b0;
  endtask

  // WIDTH=4 instance: ch0 D=0 (every cycle), ch1 D=15 (every 16 cycles).
  task automatic test_extremes();
    logic [1:0] exp_en, exp_sq;
    do_reset();
    bus_s.ld     = 1'b1;
    bus_s.ld_ch  = 4'd0;
    bus_s.ld_val = 4'd0;
    tick();
    bus_s.ld_ch  = 4'd1;
    bus_s.ld_val = 4'd15;
    tick();
    bus_s.ld = 1'b0;
    tick();
    checks++; if (bus_s.pend !== 2'b00) begin errors++; $display("FAIL ext_pend got=%b exp=00", bus_s.pend); end
    bus_s.run = 2'b11;
    for (int k = 1; k <= 34; k++) begin
      tick();
      exp_en = {((k - 1) % 16 == 0), 1'b1};
      exp_sq = {(((k - 1) / 16) % 2 == 0), (k % 2 == 1)};
      checks++; if (bus_s.en !== exp_en) begin errors++; $display("FAIL ext_en k=%0d got=%b exp=%b", k, bus_s.en, exp_en); end
      checks++; if (bus_s.sq !== exp_sq) begin errors++; $display("FAIL ext_sq k=%0d got=%b exp=%b", k, bus_s.sq, exp_sq); end
    end
    bus_s.run = 2'b00;
  endtask

  // Reset between edges while en/sq/pend are all high, then restart at
  // DEF_DIV; an out-of-range ld_ch must leave every channel untouched.
  task automatic test_reset_mid();
    logic [3:0] exp_en;
    do_reset();
    bus.run    = 4'b0001;
    bus.ld     = 1'b1;
    bus.ld_ch  = 4'd0;
    bus.ld_val = 18'd9;
    tick();
    bus.ld = 1'b0;
    checks++; if (bus.en !== 4'b0001 || bus.sq !== 4'b0001 || bus.pend !== 4'b0001) begin
      errors++; $display("FAIL rstmid_pre got en=%b sq=%b pend=%b exp 0001 each", bus.en, bus.sq, bus.pend);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.en !== 4'b0000)   begin errors++; $display("FAIL rstmid_en got=%b exp=0000", bus.en); end
    checks++; if (bus.sq !== 4'b0000)   begin errors++; $display("FAIL rstmid_sq got=%b exp=0000", bus.sq); end
    checks++; if (bus.pend !== 4'b0000) begin errors++; $display("FAIL rstmid_pend got=%b exp=0000", bus.pend); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_en = ((k - 1) % 4 == 0) ? 4'b0001 : 4'b0000;
      checks++; if (bus.en !== exp_en)     begin errors++; $display("FAIL rstmid_run_en k=%0d got=%b exp=%b", k, bus.en, exp_en); end
      checks++; if (bus.pend !== 4'b0000)  begin errors++; $display("FAIL rstmid_badch_pend k=%0d got=%b exp=0000", k, bus.pend); end
      bus.ld     = (k == 2);
      bus.ld_ch  = 4'd5;
      bus.ld_val = 18'd1;
    end
    bus.ld  = 1'b0;
    bus.run = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_mid();
    test_load_terminal();
    test_sync();
    test_extremes();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
